// File: rtl/pipelined_addsub.sv
// Segmented carry-lookahead adder/subtractor, one segment per pipeline stage,
// with an elastic valid/ready handshake on both sides.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int SEG = WIDTH / STAGES;

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] rdy;

    // Returns {carry_out, sum}; every carry is a flat generate/propagate term.
    function automatic logic [SEG:0] cla(
        input logic [SEG-1:0] x,
        input logic [SEG-1:0] y,
        input logic           ci
    );
        logic [SEG-1:0] g;
        logic [SEG-1:0] p;
        logic [SEG:0]   c;
        logic           t;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            c[i+1] = g[i];
            t      = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i+1] = c[i+1] | (t & g[j]);
                t      = t & p[j];
            end
            c[i+1] = c[i+1] | (t & ci);
        end
        return {c[SEG], p ^ c[SEG-1:0]};
    endfunction

    assign in_ready  = rdy[0] && !reset;
    assign out_valid = vld[STAGES-1];

    for (genvar k = 0; k < STAGES; k++) begin : st
        localparam int REM  = WIDTH - k * SEG;
        localparam int DONE = (k + 1) * SEG;

        logic            v_i;
        logic            c_i;
        logic [REM-1:0]  a_i;
        logic [REM-1:0]  be_i;
        logic [SEG:0]    res;
        logic [DONE-1:0] s_n;
        logic            v_q;
        logic            c_q;
        logic [DONE-1:0] s_q;

        if (k == 0) begin : src
            assign v_i  = in_valid;
            assign a_i  = a;
            assign be_i = sub ? ~b : b;
            assign c_i  = sub | cin;
            assign s_n  = res[SEG-1:0];
        end else begin : src
            assign v_i  = st[k-1].v_q;
            assign a_i  = st[k-1].fwd.a_q;
            assign be_i = st[k-1].fwd.be_q;
            assign c_i  = st[k-1].c_q;
            assign s_n  = {res[SEG-1:0], st[k-1].s_q};
        end

        assign res    = cla(a_i[SEG-1:0], be_i[SEG-1:0], c_i);
        // Ready unrolled: stage k can move unless it and everything after is full.
        assign rdy[k] = out_ready || !(&vld[STAGES-1:k]);
        assign vld[k] = v_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (rdy[k]) begin
                v_q <= v_i;
                if (v_i) begin
                    c_q <= res[SEG];
                    s_q <= s_n;
                end
            end
        end

        if (k < STAGES - 1) begin : fwd
            logic [REM-SEG-1:0] a_q;
            logic [REM-SEG-1:0] be_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    a_q  <= '0;
                    be_q <= '0;
                end else if (rdy[k] && v_i) begin
                    a_q  <= a_i[REM-1:SEG];
                    be_q <= be_i[REM-1:SEG];
                end
            end
        end else begin : fin
            logic o_q;
            logic z_q;

            always_ff @(posedge clock) begin
                if (reset) begin
                    o_q <= 1'b0;
                    z_q <= 1'b0;
                end else if (rdy[k] && v_i) begin
                    o_q <= (a_i[SEG-1] == be_i[SEG-1]) &&
                           (res[SEG-1] != a_i[SEG-1]);
                    z_q <= ~|s_n;
                end
            end

            assign s        = s_q;
            assign cout     = c_q;
            assign overflow = o_q;
            assign zero     = z_q;
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: 32-bit/4-stage and 8-bit/1-stage
// instances, covering latency, flags, back-pressure and reset flush.
module tb_pipelined_addsub;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, sub, cin;
    logic        out_valid, out_ready, cout, overflow, zero;
    logic [31:0] a, b, s;

    logic        in_valid8, in_ready8, sub8, cin8;
    logic        out_valid8, out_ready8, cout8, overflow8, zero8;
    logic [7:0]  a8, b8, s8;

    int tests = 0;
    int failed = 0;

    always #5 clock = ~clock;

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .overflow(overflow), .zero(zero)
    );

    pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut8 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .sub(sub8), .cin(cin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .s(s8), .cout(cout8), .overflow(overflow8), .zero(zero8)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference result packed as {overflow, zero, cout, s}.
    function automatic logic [34:0] ref_op(input logic [31:0] ra,
                                           input logic [31:0] rb,
                                           input logic rsub, input logic rcin);
        logic [31:0] be;
        logic [32:0] sum;
        logic        ovf;
        be  = rsub ? ~rb : rb;
        sum = {1'b0, ra} + {1'b0, be} + {32'd0, rsub | rcin};
        ovf = (ra[31] == be[31]) && (sum[31] != ra[31]);
        return {ovf, sum[31:0] == 32'd0, sum[32], sum[31:0]};
    endfunction

    task automatic op32(input string tag, input logic [31:0] ta,
                        input logic [31:0] tb, input logic tsub,
                        input logic tcin, input logic [31:0] es,
                        input logic ec, input logic eo, input logic ez);
        int n;
        @(negedge clock);
        a = ta; b = tb; sub = tsub; cin = tcin;
        in_valid = 1'b1; out_ready = 1'b1;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clock);
        #1 in_valid = 1'b0;
        n = 0;
        while (n < 10) begin
            @(negedge clock);
            n++;
            if (out_valid) break;
        end
        check({tag, " latency"}, 64'(n), 64'd4);
        check({tag, " s"}, 64'(s), 64'(es));
        check({tag, " flags"}, 64'({cout, overflow, zero}),
              64'({ec, eo, ez}));
    endtask

    logic [31:0] va [10] = '{32'h12345678, 32'hFFFFFFFF, 32'h00000010,
                            32'h80000000, 32'h7FFFFFFF, 32'hDEADBEEF,
                            32'h00000000, 32'h0000FFFF, 32'h80000000,
                            32'h00000005};
    logic [31:0] vb [10] = '{32'h11111111, 32'h00000001, 32'h00000020,
                            32'h80000000, 32'hFFFFFFFF, 32'h01234567,
                            32'h00000000, 32'h00000001, 32'h7FFFFFFF,
                            32'h00000006};
    logic        vs [10] = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    logic        vc [10] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [34:0] q [$];
        logic [34:0] e, hold;
        logic        have_hold, seen;
        int          idx, got;

        reset = 1'b1;
        in_valid = 0; a = 0; b = 0; sub = 0; cin = 0; out_ready = 1;
        in_valid8 = 0; a8 = 0; b8 = 0; sub8 = 0; cin8 = 0; out_ready8 = 1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset outputs", 64'({s, cout, overflow, zero}), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset out_valid8", 64'({out_valid8, s8}), 64'd0);
        reset = 1'b0;
        #1 check("post-reset in_ready", 64'(in_ready), 64'd1);

        op32("add ovf", 32'h7FFFFFFF, 32'h00000001, 0, 0,
             32'h80000000, 0, 1, 0);
        op32("add carry", 32'hFFFFFFFF, 32'h00000001, 0, 0,
             32'h00000000, 1, 0, 1);
        op32("sub borrow", 32'h00000000, 32'h00000001, 1, 0,
             32'hFFFFFFFF, 0, 0, 0);
        op32("sub ovf", 32'h80000000, 32'h00000001, 1, 0,
             32'h7FFFFFFF, 1, 1, 0);

        // Back-to-back stream with out_ready low in cycles 3..7.
        idx = 0; got = 0; have_hold = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clock);
            out_ready = !(cyc >= 3 && cyc <= 7);
            if (idx < 10) begin
                a = va[idx]; b = vb[idx]; sub = vs[idx]; cin = vc[idx];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("stream extra", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    check($sformatf("stream res%0d", got),
                          64'({overflow, zero, cout, s}), 64'(e));
                    got++;
                end
                have_hold = 0;
            end else if (out_valid) begin
                if (!have_hold) begin
                    hold = {overflow, zero, cout, s};
                    have_hold = 1;
                end else begin
                    check("stall hold", 64'({overflow, zero, cout, s}),
                          64'(hold));
                end
            end
            if (cyc == 5) begin
                check("stall in_ready", 64'(in_ready), 64'd0);
                check("stall tokens", 64'(idx), 64'd4);
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_op(va[idx], vb[idx], vs[idx], vc[idx]));
                idx++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream issued", 64'(idx), 64'd10);
        check("stream count", 64'(got), 64'd10);

        // Flush three in-flight ops with a one-cycle reset.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            a = 32'(i + 1); b = 32'h00000010; sub = 0; cin = 0;
            in_valid = 1'b1;
        end
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        check("flush out_valid", 64'(out_valid), 64'd0);
        check("flush outputs", 64'({s, cout, overflow, zero}), 64'd0);
        check("flush in_ready", 64'(in_ready), 64'd0);
        reset = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clock);
            if (out_valid) seen = 1;
        end
        check("flush no ghost", 64'(seen), 64'd0);
        op32("post flush", 32'h00000100, 32'h00000023, 1, 0,
             32'h000000DD, 1, 0, 0);

        // 8-bit single-stage instance.
        @(negedge clock);
        a8 = 8'h80; b8 = 8'h01; sub8 = 1; cin8 = 0; in_valid8 = 1;
        check("w8 in_ready", 64'(in_ready8), 64'd1);
        @(posedge clock);
        #1 in_valid8 = 0;
        @(negedge clock);
        check("w8 latency", 64'(out_valid8), 64'd1);
        check("w8 s", 64'(s8), 64'h7F);
        check("w8 flags", 64'({cout8, overflow8, zero8}), 64'b110);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
